// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side bundles of the unified-memory port arbiter.
// On the CPU bundle the core is master; on the memory bundle the arbiter is master.
interface mem_port_arbiter_cpu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE_W = 2
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifDone;
  logic [DATA_W-1:0] ifData;
  logic              dRead;
  logic              dWrite;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWData;
  logic [MODE_W-1:0] dMode;
  logic              dDone;
  logic [DATA_W-1:0] dRData;
  logic              holdPipe;
  logic              busErr;

  modport master (
    output ifReq, ifAddr, dRead, dWrite, dAddr, dWData, dMode,
    input  ifDone, ifData, dDone, dRData, holdPipe, busErr
  );
  modport slave (
    input  ifReq, ifAddr, dRead, dWrite, dAddr, dWData, dMode,
    output ifDone, ifData, dDone, dRData, holdPipe, busErr
  );
endinterface

interface mem_port_arbiter_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE_W = 2
);
  logic              mReq;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWData;
  logic [MODE_W-1:0] mMode;
  logic              mAck;
  logic [DATA_W-1:0] mRData;

  modport master (
    output mReq, mWe, mAddr, mWData, mMode,
    input  mAck, mRData
  );
  modport slave (
    input  mReq, mWe, mAddr, mWData, mMode,
    output mAck, mRData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports of the CPU onto one variable-latency memory,
// data first, with a timeout abort and a combinational pipeline hold.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MODE_W   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_cpu_if.slave cpu,
  mem_port_arbiter_mem_if.master mem
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mWe;
  logic [ADDR_W-1:0] r_mAddr;
  logic [DATA_W-1:0] r_mWData;
  logic [MODE_W-1:0] r_mMode;
  logic              r_dDone;
  logic              r_ifDone;
  logic [DATA_W-1:0] r_dRData;
  logic [DATA_W-1:0] r_ifData;
  logic              r_busErr;

  logic w_dReq, w_dPend, w_ifPend, w_busy, w_tout, w_fin, w_enterD, w_enterI;

  // A requester whose done is pulsing this cycle still holds its request; mask it.
  assign w_dReq   = cpu.dRead | cpu.dWrite;
  assign w_dPend  = w_dReq & ~r_dDone;
  assign w_ifPend = cpu.ifReq & ~r_ifDone;
  assign w_busy   = (r_state != S_IDLE);
  assign w_tout   = w_busy & ~mem.mAck & (r_wait == WAIT_LAST);
  assign w_fin    = w_busy & (mem.mAck | w_tout);
  assign w_enterD = (w_next == S_DATA) & (r_state != S_DATA);
  assign w_enterI = (w_next == S_INST) & (r_state != S_INST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_dPend)       w_next = S_DATA;
        else if (w_ifPend) w_next = S_INST;
      end
      S_DATA: if (w_fin) w_next = w_ifPend ? S_INST : S_IDLE;
      S_INST: if (w_fin) w_next = w_dPend ? S_DATA : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait   <= '0;
      r_mWe    <= 1'b0;
      r_mAddr  <= '0;
      r_mWData <= '0;
      r_mMode  <= '0;
      r_dDone  <= 1'b0;
      r_ifDone <= 1'b0;
      r_dRData <= '0;
      r_ifData <= '0;
      r_busErr <= 1'b0;
    end else begin
      r_dDone  <= (r_state == S_DATA) & w_fin;
      r_ifDone <= (r_state == S_INST) & w_fin;
      if (w_tout) r_busErr <= 1'b1;

      if (!w_busy || w_fin) r_wait <= '0;
      else                  r_wait <= r_wait + 1'b1;

      if (w_enterD) begin
        r_mAddr  <= cpu.dAddr;
        r_mWData <= cpu.dWData;
        r_mMode  <= cpu.dMode;
        r_mWe    <= cpu.dWrite;
      end else if (w_enterI) begin
        r_mAddr  <= cpu.ifAddr;
        r_mMode  <= '1;
        r_mWe    <= 1'b0;
      end

      if ((r_state == S_DATA) && w_fin) begin
        if (w_tout)      r_dRData <= '0;
        else if (!r_mWe) r_dRData <= mem.mRData;
      end
      if ((r_state == S_INST) && w_fin)
        r_ifData <= w_tout ? '0 : mem.mRData;
    end
  end

  assign mem.mReq   = w_busy;
  assign mem.mWe    = r_mWe;
  assign mem.mAddr  = r_mAddr;
  assign mem.mWData = r_mWData;
  assign mem.mMode  = r_mMode;

  assign cpu.ifDone   = r_ifDone;
  assign cpu.ifData   = r_ifData;
  assign cpu.dDone    = r_dDone;
  assign cpu.dRData   = r_dRData;
  assign cpu.busErr   = r_busErr;
  assign cpu.holdPipe = (w_dReq & ~r_dDone) | (cpu.ifReq & ~r_ifDone);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder with programmable
// ack latency plus hand-computed expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MODE_W = 2;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_cpu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE_W(MODE_W)) cpu ();
  mem_port_arbiter_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE_W(MODE_W)) mem ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE_W(MODE_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .mem   (mem)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder and bus monitor; ack arrives after mem_lat extra mReq cycles,
  // read data is either fixed or a function of the address.
  int          mem_lat = 0;
  logic        mem_en = 1'b1, mem_fixed = 1'b0, spur = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          mem_cnt = 0;
  int          n_ifdone = 0, n_ddone = 0, n_hi = 0, n_drop = 0, n_unst = 0;
  logic        prev_req = 1'b0;
  logic [66:0] prev_bus = '0;
  logic [66:0] bus;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [1:0]  last_mode = '0;

  always @(negedge clk) begin
    bus = {mem.mWe, mem.mAddr, mem.mWData, mem.mMode};
    if (mem.mReq && prev_req && !mem.mAck && bus != prev_bus) n_unst++;
    if (mem.mReq) begin
      n_hi++;
      last_we = mem.mWe; last_addr = mem.mAddr; last_wdata = mem.mWData; last_mode = mem.mMode;
    end
    if (prev_req && !mem.mReq) n_drop++;
    prev_req = mem.mReq;
    prev_bus = bus;
    if (cpu.dDone === 1'b1)  n_ddone++;
    if (cpu.ifDone === 1'b1) n_ifdone++;
    mem.mAck = 1'b0;
    if (spur) mem.mAck = 1'b1;
    else if (mem.mReq && mem_en) begin
      if (mem_cnt >= mem_lat) begin mem.mAck = 1'b1; mem_cnt = 0; end
      else mem_cnt++;
    end else mem_cnt = 0;
    mem.mRData = mem_fixed ? mem_rdata : (mem.mAddr ^ 32'hA5A5_A5A5);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs from the cycle the requests were raised until all have completed and been
  // dropped; times are cycle offsets from that raise cycle.
  int          t_d, t_i, n_hold;
  logic [31:0] rd, ri;
  task automatic run_txn(input int budget);
    logic ok = 1'b0;
    logic drop_d = 1'b0, drop_i = 1'b0;
    t_d = -1; t_i = -1; n_hold = 0; rd = 'x; ri = 'x;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (cpu.holdPipe) n_hold++;
      if (cpu.dDone)  begin t_d = k; rd = cpu.dRData; drop_d = 1'b1; end
      if (cpu.ifDone) begin t_i = k; ri = cpu.ifData; drop_i = 1'b1; end
      tick();
      if (drop_d) begin cpu.dRead = 1'b0; cpu.dWrite = 1'b0; drop_d = 1'b0; end
      if (drop_i) begin cpu.ifReq = 1'b0; drop_i = 1'b0; end
      if (!cpu.dRead && !cpu.dWrite && !cpu.ifReq) begin ok = 1'b1; break; end
    end
    check("txn_completed", ok, 1'b1);
  endtask

  int s_ifd, s_dd, s_hi, s_drop, s_unst;
  task automatic snap();
    s_ifd = n_ifdone; s_dd = n_ddone; s_hi = n_hi; s_drop = n_drop; s_unst = n_unst;
  endtask

  initial begin
    reset = 1'b1;
    cpu.ifReq = 1'b0; cpu.ifAddr = '0; cpu.dRead = 1'b0; cpu.dWrite = 1'b0;
    cpu.dAddr = '0; cpu.dWData = '0; cpu.dMode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mReq", mem.mReq, 0);
    check("rst_mWe", mem.mWe, 0);
    check("rst_mAddr", mem.mAddr, 0);
    check("rst_done", {cpu.dDone, cpu.ifDone}, 0);
    check("rst_busErr", cpu.busErr, 0);
    check("rst_rdata", {cpu.dRData, cpu.ifData}, 0);
    check("rst_hold", cpu.holdPipe, 0);
    reset = 1'b0;
    tick();

    // Fetch only, ack in the third mReq cycle
    mem_lat = 2; mem_fixed = 1'b1; mem_rdata = 32'h2008_0005; snap();
    cpu.ifReq = 1'b1; cpu.ifAddr = 32'h0040_0000;
    run_txn(40);
    repeat (3) tick();
    check("f_ifDone_cyc", t_i, 4);
    check("f_ifData", ri, 32'h2008_0005);
    check("f_hold_cycles", n_hold, 4);
    check("f_mAddr", last_addr, 32'h0040_0000);
    check("f_mWe", last_we, 0);
    check("f_mMode", last_mode, 2'b11);
    check("f_ifDone_pulses", n_ifdone - s_ifd, 1);

    // Simultaneous load and fetch, zero-wait memory
    mem_lat = 0; mem_fixed = 1'b0; snap();
    cpu.dRead = 1'b1; cpu.dAddr = 32'h1001_0000; cpu.dMode = 2'b11;
    cpu.ifReq = 1'b1; cpu.ifAddr = 32'h0040_0004;
    run_txn(40);
    repeat (3) tick();
    check("b_dDone_cyc", t_d, 2);
    check("b_ifDone_cyc", t_i, 3);
    check("b_dRData", rd, 32'hB5A4_A5A5);
    check("b_ifData", ri, 32'hA5E5_A5A1);
    check("b_hold_cycles", n_hold, 3);
    check("b_mReq_cycles", n_hi - s_hi, 2);
    check("b_mReq_drops", n_drop - s_drop, 1);

    // Store with wait states
    mem_lat = 3; snap();
    cpu.dWrite = 1'b1; cpu.dAddr = 32'h1001_0008; cpu.dWData = 32'hCAFE_BABE; cpu.dMode = 2'b01;
    run_txn(40);
    repeat (3) tick();
    check("s_dDone_cyc", t_d, 5);
    check("s_dRData_kept", cpu.dRData, 32'hB5A4_A5A5);
    check("s_mWe", last_we, 1);
    check("s_mAddr", last_addr, 32'h1001_0008);
    check("s_mWData", last_wdata, 32'hCAFE_BABE);
    check("s_mMode", last_mode, 2'b01);
    check("s_stable", n_unst - s_unst, 0);
    check("s_dDone_pulses", n_ddone - s_dd, 1);
    check("s_busErr", cpu.busErr, 0);

    // Timeout on a load
    mem_en = 1'b0; snap();
    cpu.dRead = 1'b1; cpu.dAddr = 32'h1001_0010; cpu.dMode = 2'b11;
    run_txn(60);
    repeat (2) tick();
    check("t_dDone_cyc", t_d, MAX_WAIT + 1);
    check("t_dRData", rd, 0);
    check("t_mReq_cycles", n_hi - s_hi, MAX_WAIT);
    check("t_busErr", cpu.busErr, 1);

    // busErr sticks through a later good access
    mem_en = 1'b1; mem_lat = 0;
    cpu.ifReq = 1'b1; cpu.ifAddr = 32'h0040_0010;
    run_txn(40);
    repeat (2) tick();
    check("t2_ifData", ri, 32'hA5E5_A5B5);
    check("t2_busErr", cpu.busErr, 1);

    // Reset in the middle of a fetch
    mem_en = 1'b0; snap();
    cpu.ifReq = 1'b1; cpu.ifAddr = 32'h0040_0008;
    tick(); tick();
    check("r_mReq_before", mem.mReq, 1);
    reset = 1'b1;
    #1;
    check("r_mReq_async", mem.mReq, 0);
    check("r_ifData_clr", cpu.ifData, 0);
    check("r_busErr_clr", cpu.busErr, 0);
    cpu.ifReq = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("r_no_ifDone", n_ifdone - s_ifd, 0);
    mem_en = 1'b1; mem_lat = 0; snap();
    cpu.ifReq = 1'b1; cpu.ifAddr = 32'h0040_000C;
    run_txn(40);
    repeat (2) tick();
    check("r_fresh_cyc", t_i, 2);
    check("r_fresh_ifData", ri, 32'hA5E5_A5A9);
    check("r_fresh_pulses", n_ifdone - s_ifd, 1);

    // Spurious ack while idle
    snap();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    check("sp_mReq", mem.mReq, 0);
    tick(); tick();
    check("sp_mReq_later", mem.mReq, 0);
    check("sp_no_done", (n_ddone - s_dd) + (n_ifdone - s_ifd), 0);
    check("sp_ifData", cpu.ifData, 32'hA5E5_A5A9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
